// File: rtl/dmem_loader_pkg.sv
// +------------------------------------------------------------------+
// | MiniLab_defs                                                     |
// | Shared constants and types for the data-memory loader.           |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

package MiniLab_defs;

  // dmem address width; the memory holds 2^DMEM_DEPTH 16-bit words
  localparam int DMEM_DEPTH       = 8;
  localparam int LOADER_MAX_WORDS = 1 << DMEM_DEPTH;

  typedef enum logic [2:0] {
    LD_IDLE   = 3'd0,
    LD_LEN_LO = 3'd1,
    LD_LEN_HI = 3'd2,
    LD_DAT_LO = 3'd3,
    LD_DAT_HI = 3'd4,
    LD_CSUM   = 3'd5
  } loader_state_t;

  // A frame announcing more words than the memory holds is rejected
  function automatic logic len_too_big(input logic [15:0] len);
    return (32'(len) > 32'(LOADER_MAX_WORDS));
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_loader.sv
// +------------------------------------------------------------------+
// | dmem_loader                                                      |
// | Framed byte-stream loader in front of the data memory. Passes    |
// | CPU traffic through while idle, owns the dmem port while busy.   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module dmem_loader
  import MiniLab_defs::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [DMEM_DEPTH-1:0] base_i,
  input  logic                  byte_valid_i,
  input  logic [7:0]            byte_i,
  output logic                  byte_ready_o,
  input  logic                  cpu_we_i,
  input  logic [DMEM_DEPTH-1:0] cpu_addr_i,
  input  logic [15:0]           cpu_wdata_i,
  output logic                  dmem_we_o,
  output logic [DMEM_DEPTH-1:0] dmem_addr_o,
  output logic [15:0]           dmem_wdata_o,
  output logic                  cpu_stall_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  localparam logic [DMEM_DEPTH:0] C_IDX_ONE = (DMEM_DEPTH+1)'(1);

  loader_state_t         r_state;
  loader_state_t         w_next;
  logic [DMEM_DEPTH-1:0] r_base;
  logic [DMEM_DEPTH:0]   r_cnt;
  logic [DMEM_DEPTH:0]   r_idx;
  logic [7:0]            r_lo;
  logic [7:0]            r_acc;
  logic                  r_err;
  logic                  r_done;
  logic                  r_we;
  logic [DMEM_DEPTH-1:0] r_addr;
  logic [15:0]           r_wdata;

  logic                  w_busy;
  logic                  w_accept;
  logic [15:0]           w_len;
  logic                  w_last_word;

  assign w_busy      = (r_state != LD_IDLE);
  assign w_accept    = byte_valid_i & w_busy;
  // r_lo holds the length low byte while in LEN_HI
  assign w_len       = {byte_i, r_lo};
  assign w_last_word = ((r_idx + C_IDX_ONE) == r_cnt);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= LD_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic: walks the frame one accepted byte at a time
  always_comb begin
    w_next = r_state;
    case (r_state)
      LD_IDLE:   if (start_i)  w_next = LD_LEN_LO;
      LD_LEN_LO: if (w_accept) w_next = LD_LEN_HI;
      LD_LEN_HI: begin
        if (w_accept) begin
          if (w_len == 16'd0)          w_next = LD_CSUM;
          else if (len_too_big(w_len)) w_next = LD_IDLE;
          else                         w_next = LD_DAT_LO;
        end
      end
      LD_DAT_LO: if (w_accept) w_next = LD_DAT_HI;
      LD_DAT_HI: if (w_accept) w_next = w_last_word ? LD_CSUM : LD_DAT_LO;
      LD_CSUM:   if (w_accept) w_next = LD_IDLE;
      default:   w_next = LD_IDLE;
    endcase
  end

  // Datapath: length, payload assembly, checksum and registered write pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_base  <= '0;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_lo    <= '0;
      r_acc   <= '0;
      r_err   <= 1'b0;
      r_done  <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_done <= 1'b0;
      r_we   <= 1'b0;
      case (r_state)
        LD_IDLE: begin
          if (start_i) begin
            r_base <= base_i;
            r_err  <= 1'b0;
            r_acc  <= '0;
            r_idx  <= '0;
          end
        end
        LD_LEN_LO: if (w_accept) r_lo <= byte_i;
        LD_LEN_HI: begin
          if (w_accept) begin
            r_cnt <= w_len[DMEM_DEPTH:0];
            if (len_too_big(w_len)) begin
              r_err  <= 1'b1;
              r_done <= 1'b1;
            end
          end
        end
        LD_DAT_LO: begin
          if (w_accept) begin
            r_lo  <= byte_i;
            r_acc <= r_acc ^ byte_i;
          end
        end
        LD_DAT_HI: begin
          if (w_accept) begin
            r_acc   <= r_acc ^ byte_i;
            r_we    <= 1'b1;
            r_addr  <= r_base + r_idx[DMEM_DEPTH-1:0];
            r_wdata <= {byte_i, r_lo};
            r_idx   <= r_idx + C_IDX_ONE;
          end
        end
        LD_CSUM: begin
          if (w_accept) begin
            r_err  <= (byte_i != r_acc);
            r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Port mux: the loader keeps ownership (and blocks CPU writes) while busy
  always_comb begin
    dmem_we_o    = cpu_we_i;
    dmem_addr_o  = cpu_addr_i;
    dmem_wdata_o = cpu_wdata_i;
    if (w_busy) begin
      dmem_we_o    = r_we;
      dmem_addr_o  = r_addr;
      dmem_wdata_o = r_wdata;
    end
  end

  assign busy_o       = w_busy;
  assign cpu_stall_o  = w_busy;
  assign byte_ready_o = w_busy;
  assign done_o       = r_done;
  assign err_o        = r_err;

endmodule

`default_nettype wire

// File: tb/tb_dmem_loader.sv
// +------------------------------------------------------------------+
// | tb_dmem_loader                                                   |
// | Scoreboard bench for dmem_loader with a frame-level model.       |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module tb_dmem_loader;
  import MiniLab_defs::*;

  localparam int D = DMEM_DEPTH;

  logic         clk;
  logic         rst_n;
  logic         start_i;
  logic [D-1:0] base_i;
  logic         byte_valid_i;
  logic [7:0]   byte_i;
  logic         byte_ready_o;
  logic         cpu_we_i;
  logic [D-1:0] cpu_addr_i;
  logic [15:0]  cpu_wdata_i;
  logic         dmem_we_o;
  logic [D-1:0] dmem_addr_o;
  logic [15:0]  dmem_wdata_o;
  logic         cpu_stall_o;
  logic         busy_o;
  logic         done_o;
  logic         err_o;

  typedef struct packed {
    logic [D-1:0] addr;
    logic [15:0]  data;
  } wr_t;

  wr_t         exp_wr[$];
  logic        exp_err[$];
  logic [15:0] frame_words[$];
  logic [15:0] mem [0:(1<<D)-1];

  int n_checks = 0;
  int n_fail   = 0;

  dmem_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .base_i       (base_i),
    .byte_valid_i (byte_valid_i),
    .byte_i       (byte_i),
    .byte_ready_o (byte_ready_o),
    .cpu_we_i     (cpu_we_i),
    .cpu_addr_i   (cpu_addr_i),
    .cpu_wdata_i  (cpu_wdata_i),
    .dmem_we_o    (dmem_we_o),
    .dmem_addr_o  (dmem_addr_o),
    .dmem_wdata_o (dmem_wdata_o),
    .cpu_stall_o  (cpu_stall_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: every dmem write and every done pulse is matched against the scoreboard
  always @(posedge clk) begin
    #2;
    if (rst_n) begin
      if (dmem_we_o) begin
        mem[dmem_addr_o] = dmem_wdata_o;
        if (exp_wr.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, none expected",
                   dmem_addr_o, dmem_wdata_o);
        end else begin
          wr_t e;
          e = exp_wr.pop_front();
          check("wr_addr", 32'(dmem_addr_o), 32'(e.addr));
          check("wr_data", 32'(dmem_wdata_o), 32'(e.data));
        end
      end
      if (done_o) begin
        check("busy_low_at_done", 32'(busy_o), 32'd0);
        if (exp_err.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got done with err=%0d, none expected", err_o);
        end else begin
          logic ee;
          ee = exp_err.pop_front();
          check("done_err", 32'(err_o), 32'(ee));
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bit sent;
    int guard;
    sent  = 0;
    guard = 0;
    while (!sent) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) begin
        byte_valid_i = 1'b0;
      end else begin
        byte_valid_i = 1'b1;
        byte_i       = b;
        if (byte_ready_o) sent = 1;
      end
      guard++;
      if (!sent && guard > 40) begin
        check("byte_accept_timeout", 32'd0, 32'd1);
        sent = 1;
      end
    end
  endtask

  task automatic do_start(input logic [D-1:0] b);
    @(negedge clk);
    start_i      = 1'b1;
    base_i       = b;
    byte_valid_i = 1'b0;
    @(negedge clk);
    start_i = 1'b0;
    check("busy_after_start", 32'(busy_o), 32'd1);
    check("stall_after_start", 32'(cpu_stall_o), 32'd1);
    check("err_cleared_on_start", 32'(err_o), 32'd0);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && busy_o; i++) @(negedge clk);
    check("load_completes", 32'(busy_o), 32'd0);
  endtask

  // Model: every word lands at (base + i) mod 2^D; checksum is XOR of payload bytes
  task automatic run_frame(input logic [D-1:0] base, input logic [15:0] cnt,
                           input logic [7:0] csum_delta);
    logic [7:0] acc;
    bit         over;
    acc  = 8'h00;
    over = (int'(cnt) > LOADER_MAX_WORDS);
    if (over) begin
      exp_err.push_back(1'b1);
    end else begin
      for (int i = 0; i < int'(cnt); i++) begin
        wr_t e;
        e.addr = base + D'(i);
        e.data = frame_words[i];
        acc    = acc ^ frame_words[i][7:0] ^ frame_words[i][15:8];
        exp_wr.push_back(e);
      end
      exp_err.push_back(csum_delta != 8'h00);
    end
    do_start(base);
    send_byte(cnt[7:0]);
    send_byte(cnt[15:8]);
    if (!over) begin
      for (int i = 0; i < int'(cnt); i++) begin
        send_byte(frame_words[i][7:0]);
        send_byte(frame_words[i][15:8]);
      end
      send_byte(acc ^ csum_delta);
    end
    @(negedge clk);
    byte_valid_i = 1'b0;
    wait_idle();
  endtask

  initial begin
    rst_n        = 1'b0;
    start_i      = 1'b0;
    base_i       = '0;
    byte_valid_i = 1'b0;
    byte_i       = 8'h00;
    cpu_we_i     = 1'b0;
    cpu_addr_i   = 8'h42;
    cpu_wdata_i  = 16'hBEEF;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state and combinational pass-through
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_ready", 32'(byte_ready_o), 32'd0);
    check("pass_addr", 32'(dmem_addr_o), 32'h42);
    check("pass_wdata", 32'(dmem_wdata_o), 32'hBEEF);
    check("pass_we", 32'(dmem_we_o), 32'd0);

    // Idle CPU write goes straight through
    begin
      wr_t e;
      e.addr = 8'h42;
      e.data = 16'hBEEF;
      exp_wr.push_back(e);
    end
    cpu_we_i = 1'b1;
    @(negedge clk);
    cpu_we_i = 1'b0;

    // Good two-word frame, checksum 08
    frame_words = '{16'h1234, 16'h5678};
    run_frame(8'h10, 16'd2, 8'h00);
    check("err_good", 32'(err_o), 32'd0);
    check("mem_read_0x11", 32'(mem[8'h11]), 32'h5678);

    // Same frame with checksum 09
    run_frame(8'h10, 16'd2, 8'h01);
    repeat (3) @(negedge clk);
    check("err_held", 32'(err_o), 32'd1);

    // Address wrap at top of memory
    frame_words = '{16'hA1B2, 16'hC3D4};
    run_frame(8'hFF, 16'd2, 8'h00);

    // Empty frame
    run_frame(8'h20, 16'd0, 8'h00);
    check("err_empty", 32'(err_o), 32'd0);

    // Oversized count: rejected after the length bytes
    run_frame(8'h00, 16'(LOADER_MAX_WORDS + 1), 8'h00);
    check("err_over", 32'(err_o), 32'd1);
    @(negedge clk);
    byte_valid_i = 1'b1;
    byte_i       = 8'hAA;
    #1;
    check("no_ready_idle", 32'(byte_ready_o), 32'd0);
    repeat (2) @(negedge clk);
    byte_valid_i = 1'b0;
    check("still_idle", 32'(busy_o), 32'd0);

    // Randomized frames
    for (int f = 0; f < 12; f++) begin
      int         n;
      logic [7:0] delta;
      n = $urandom_range(1, 6);
      frame_words = {};
      for (int i = 0; i < n; i++) frame_words.push_back(16'($urandom));
      delta = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      run_frame(D'($urandom), 16'(n), delta);
    end

    // CPU write blocked, restart ignored, reset after one data word
    begin
      wr_t e;
      e.addr = 8'h30;
      e.data = 16'h9ABC;
      exp_wr.push_back(e);
    end
    do_start(8'h30);
    cpu_we_i    = 1'b1;
    cpu_addr_i  = 8'h99;
    cpu_wdata_i = 16'hDEAD;
    send_byte(8'h03);
    send_byte(8'h00);
    @(negedge clk);
    byte_valid_i = 1'b0;
    start_i      = 1'b1;
    base_i       = 8'h70;
    @(negedge clk);
    start_i = 1'b0;
    send_byte(8'hBC);
    send_byte(8'h9A);
    @(negedge clk);
    byte_valid_i = 1'b0;
    @(negedge clk);
    check("busy_mid_load", 32'(busy_o), 32'd1);
    check("cpu_we_blocked", 32'(dmem_we_o), 32'd0);
    rst_n    = 1'b0;
    cpu_we_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_mid_busy", 32'(busy_o), 32'd0);
    check("rst_mid_err", 32'(err_o), 32'd0);
    check("rst_mid_done", 32'(done_o), 32'd0);
    begin
      wr_t e;
      e.addr = 8'h99;
      e.data = 16'hDEAD;
      exp_wr.push_back(e);
    end
    cpu_we_i = 1'b1;
    #1;
    check("pass_resume_we", 32'(dmem_we_o), 32'd1);
    check("pass_resume_addr", 32'(dmem_addr_o), 32'h99);
    @(negedge clk);
    cpu_we_i = 1'b0;
    repeat (4) @(negedge clk);

    check("writes_drained", 32'(exp_wr.size()), 32'd0);
    check("dones_drained", 32'(exp_err.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/dmem_loader.md
# dmem_loader

Upstream write-side front end for the data memory. Accepts a framed little-endian byte stream (from the SPART receive path) and writes 16-bit words into `dmem` starting at a programmable base address. While idle it passes CPU write/address traffic straight through to `dmem`; while loading it owns the port and stalls the CPU. Frame: 2-byte word count, count×2 payload bytes, 1-byte XOR checksum.

## Interface
Parameters (from `MiniLab_defs`):
- `DMEM_DEPTH`, package constant; dmem address width, with 2^DMEM_DEPTH entries.

Ports:
- `clk`  in  1  system clock; all logic on posedge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `start_i`  in  1  begin a load; ignored while `busy_o`=1.
- `base_i`  in  DMEM_DEPTH  first write address; sampled on accepted `start_i`.
- `byte_valid_i`  in  1  stream byte valid.
- `byte_i`  in  8  stream byte.
- `byte_ready_o`  out  1  loader accepts a byte this cycle.
- `cpu_we_i`  in  1  CPU write enable.
- `cpu_addr_i`  in  DMEM_DEPTH  CPU address.
- `cpu_wdata_i`  in  16  CPU write data.
- `dmem_we_o`  out  1  to `dmem.we_i`.
- `dmem_addr_o`  out  DMEM_DEPTH  to `dmem.addr_i`.
- `dmem_wdata_o`  out  16  to `dmem.wdata_i`.
- `cpu_stall_o`  out  1  equals `busy_o`.
- `busy_o`  out  1  load in progress.
- `done_o`  out  1  one-cycle pulse at end of load, whether it passed or failed.
- `err_o`  out  1  last load failed; held until the next accepted start or reset.

## Operation
- FSM states: IDLE, LEN_LO, LEN_HI, DAT_LO, DAT_HI, CSUM.
- IDLE with `start_i`: latch `base_i`, clear `err_o`, clear the XOR accumulator, go to LEN_LO.
- A byte transfers on a posedge with `byte_valid_i`&`byte_ready_o`. `byte_ready_o`=1 in every state except IDLE.
- LEN_LO→LEN_HI→ count register `cnt` is DMEM_DEPTH+1 bits, assembled low byte then high byte.
- Leaving LEN_HI:
  - `cnt`==0: go to CSUM.
  - `cnt` > 2^DMEM_DEPTH: set `err_o`, pulse `done_o`, return to IDLE.
  - Otherwise: go to DAT_LO.
- DAT_LO latches the low byte. DAT_HI accepting the high byte issues a one-cycle write of {hi,lo} at address `base+idx`.
  - `idx` increments after each write.
  - The address wraps modulo 2^DMEM_DEPTH.
  - After the `cnt`-th word, go to CSUM; otherwise go back to DAT_LO.
- The accumulator XORs every payload byte; length bytes are excluded.
- CSUM on accept:
  - `err_o` = (byte ≠ accumulator).
  - Pulse `done_o` and go to IDLE.
  - Words already written are not rolled back.
- Port mux:
  - `busy_o`=0: `dmem_*_o` = `cpu_*_i` combinationally.
  - `busy_o`=1: loader drives `dmem_*_o`. `cpu_we_i` is blocked. `dmem_we_o`=0 except on write pulses.
- `start_i` while busy: ignored. Bytes offered in IDLE: not accepted.

## Timing
- Reset values: state IDLE, `busy_o`=0, `done_o`=0, `err_o`=0, `byte_ready_o`=0, internal registers 0. The `dmem_*_o` outputs follow CPU pass-through.
- `busy_o` rises the cycle after the start is accepted, and falls the same cycle `done_o` pulses.
- Write pulse: loader `dmem_we/addr/wdata` are registered and asserted the cycle after the DAT_HI byte accept. `dmem` samples them on the negedge within that cycle.
- Throughput: one byte per cycle. Minimum load of N words = 2+2N+1 accepting cycles plus 1.
- The last data write pulse coincides with the first CSUM cycle. The mux must keep loader ownership until `busy_o` falls.
- Reset mid-load: IDLE next cycle, no further writes, `err_o`=0, no `done_o`.

## Structure
- Add to `MiniLab_defs`:
  - `typedef enum logic [2:0] loader_state_t`.
  - `LOADER_MAX_WORDS = 1<<DMEM_DEPTH`.
- Single module with no sub-module.
- Top level instantiates `dmem_loader` between CPU and `dmem`. `dmem.rdata_o` goes straight to the CPU.

## Test plan
- Base 0x010, stream 02 00 | 34 12 | 78 56 | 08 → writes 0x1234@0x010 and 0x5678@0x011; `done_o` pulse; `err_o`=0. A CPU read of 0x011 returns 0x5678.
- Same frame with checksum 0x09 → both words written; `done_o` pulse; `err_o`=1 until the next start.
- Base = 2^DMEM_DEPTH−1, count 2 → second write lands at address 0 (wrap).
- Count 00 00, checksum 00 → no `dmem_we_o`; `done_o` after 3 bytes; `err_o`=0.
- Count = 2^DMEM_DEPTH+1 → `err_o`=1 and `done_o` after LEN_HI; no writes; `byte_ready_o`=0 afterwards.
- `cpu_we_i`=1 during a load, `start_i` re-pulsed mid-load, `rst_n`=0 after 1 data word → CPU write suppressed, re-start ignored. Reset returns to IDLE and CPU pass-through resumes the next cycle.
